// File: rtl/multicycle_adder_pkg.sv
// rtl/multicycle_adder_pkg.sv - shared FSM encoding and mode constants for multicycle_adder
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/adder_chunk.sv
// rtl/adder_chunk.sv - CHUNK-bit ripple adder built from fulladder cells
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_outc,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        fulladder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_c[i]),
            .o_s (o_sum[i]),
            .o_c (w_c[i+1])
        );
    end

    // Carry into the top bit is needed for signed overflow on the final slice.
    assign o_outc = w_c[CHUNK];
    assign o_cmsb = w_c[CHUNK-1];

endmodule

// File: rtl/fulladder.sv
// rtl/fulladder.sv - single-bit full adder cell
module fulladder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/multicycle_adder.sv
// rtl/multicycle_adder.sv - WIDTH-bit add/subtract computed CHUNK bits per cycle
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             inputc,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             outc,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("multicycle_adder: WIDTH must be an integer multiple of CHUNK");
    end

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_outc;
    logic               r_ovf;
    logic [IDX_W-1:0]   r_idx;
    logic [BASE_W-1:0]  w_base;
    logic [CHUNK-1:0]   w_slice_sum;
    logic               w_slice_c;
    logic               w_slice_cmsb;

    assign w_base = BASE_W'(32'(r_idx) * CHUNK);

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .i_a    (r_a[w_base +: CHUNK]),
        .i_b    (r_b[w_base +: CHUNK]),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_outc (w_slice_c),
        .o_cmsb (w_slice_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // in_ready is gated by rst_n so it reads 0 while reset is held.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = rst_n;
                if (in_valid) w_next = ST_RUN;
            end
            ST_RUN: begin
                if (r_idx == LAST_IDX) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_outc  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= input1;
                        r_b     <= (mode == MODE_SUB) ? ~input2 : input2;
                        r_carry <= (mode == MODE_SUB) ? 1'b1 : inputc;
                        r_idx   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sum[w_base +: CHUNK] <= w_slice_sum;
                    r_carry                <= w_slice_c;
                    if (r_idx == LAST_IDX) begin
                        r_outc <= w_slice_c;
                        r_ovf  <= w_slice_cmsb ^ w_slice_c;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = r_sum;
    assign outc     = r_outc;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_multicycle_adder.sv
// tb/tb_multicycle_adder.sv - scoreboard bench over CHUNK = 1,2,4,8,16 at WIDTH = 16
module tb_multicycle_adder;

    localparam int NDUT = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [15:0]       input1;
    logic [15:0]       input2;
    logic              inputc;
    logic              mode;
    logic              out_ready;
    logic [NDUT-1:0]   w_ir;
    logic [NDUT-1:0]   w_ov;
    logic [NDUT-1:0]   w_oc;
    logic [NDUT-1:0]   w_ovf;
    logic [15:0]       w_sum [NDUT];

    int n_chk  = 0;
    int n_pass = 0;
    logic [17:0] exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        multicycle_adder #(.WIDTH(16), .CHUNK(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (w_ir[g]),
            .input1    (input1),
            .input2    (input2),
            .inputc    (inputc),
            .mode      (mode),
            .out_valid (w_ov[g]),
            .out_ready (out_ready),
            .sum       (w_sum[g]),
            .outc      (w_oc[g]),
            .overflow  (w_ovf[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic m);
        logic [16:0] r;
        logic [15:0] bb;
        logic        v;
        bb = m ? ~b : b;
        r  = {1'b0, a} + {1'b0, bb} + {16'd0, (m ? 1'b1 : c)};
        v  = (a[15] == bb[15]) && (r[15] != a[15]);
        return {v, r[16], r[15:0]};
    endfunction

    function automatic logic [17:0] result(input int g);
        return {w_ovf[g], w_oc[g], w_sum[g]};
    endfunction

    // Called #1 after a rising edge with every DUT idle; leaves the same phase.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic m, input logic [17:0] e, input int hold);
        logic [NDUT-1:0] seen;
        int              lat [NDUT];
        logic [17:0]     exp_v;
        check("ready_before_op", 32'(w_ir), 32'h1f);
        exp_q.push_back(e);
        input1 = a; input2 = b; inputc = c; mode = m; in_valid = 1'b1;
        seen = '0;
        for (int g = 0; g < NDUT; g++) lat[g] = 0;
        for (int cyc = 1; cyc <= 40 && seen != 5'h1f; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                in_valid = 1'b0;
                input1 = ~a; input2 = ~b; inputc = ~c; mode = ~m;
                check("ready_busy", 32'(w_ir), 32'h0);
            end
            for (int g = 0; g < NDUT; g++)
                if (!seen[g] && w_ov[g]) begin seen[g] = 1'b1; lat[g] = cyc; end
        end
        check("out_valid_timeout", 32'(seen), 32'h1f);
        exp_v = exp_q.pop_front();
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("result_chunk%0d", 1 << g), 32'(result(g)), 32'(exp_v));
            check($sformatf("latency_chunk%0d", 1 << g), lat[g], 16 / (1 << g) + 1);
        end
        for (int h = 0; h < hold; h++) begin
            if (h == 3) begin in_valid = 1'b1; input1 = 16'hAAAA; input2 = 16'h5555; end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_valid_held", 32'(w_ov), 32'h1f);
            check("bp_ready_low", 32'(w_ir), 32'h0);
            for (int g = 0; g < NDUT; g++)
                check("bp_result_stable", 32'(result(g)), 32'(exp_v));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_handshake", 32'(w_ir), 32'h1f);
        check("valid_dropped", 32'(w_ov), 32'h0);
        for (int g = 0; g < NDUT; g++)
            check("result_kept", 32'(result(g)), 32'(exp_v));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [15:0] a, b;
        logic        c, m;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        input1 = '0; input2 = '0; inputc = 1'b0; mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(w_ir), 32'h0);
        check("reset_valid", 32'(w_ov), 32'h0);
        for (int g = 0; g < NDUT; g++) check("reset_result", 32'(result(g)), 32'h0);
        rst_n = 1'b1;
        #1;
        check("ready_on_release", 32'(w_ir), 32'h1f);
        @(posedge clk); #1;
        check("ready_first_cycle", 32'(w_ir), 32'h1f);

        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 18'h02345, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF, 0);
        do_op(16'h0001, 16'h0002, 1'b0, 1'b1, 18'h0FFFF, 0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 18'h10000, 0);
        do_op(16'h0001, 16'h0002, 1'b1, 1'b1, 18'h0FFFF, 0);
        do_op(16'hBEEF, 16'h1357, 1'b0, 1'b0, model(16'hBEEF, 16'h1357, 1'b0, 1'b0), 10);
        do_op(16'h0010, 16'h0020, 1'b0, 1'b0, 18'h00030, 0);

        // Abort mid-RUN: every DUT must zero its outputs while rst_n is low.
        input1 = 16'h4321; input2 = 16'h1234; inputc = 1'b0; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(w_ir), 32'h0);
        check("abort_valid", 32'(w_ov), 32'h0);
        for (int g = 0; g < NDUT; g++) check("abort_result", 32'(result(g)), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("abort_release_ready", 32'(w_ir), 32'h1f);
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 18'h00007, 0);

        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            c = 1'($urandom); m = 1'($urandom);
            if (i < 8) begin a = (i[0]) ? 16'hFFFF : 16'h8000; b = (i[1]) ? 16'h7FFF : 16'hFFFF; end
            do_op(a, b, c, m, model(a, b, c, m), 0);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
